// File: rtl/fpu_norm_shift_pipe.sv
// fpu_norm_shift_pipe: two-stage left-normalizer with exponent adjust and denormal clamp
module fpu_norm_shift_pipe #(
  parameter int SWR = 55,
  parameter int EW  = 11,
  parameter int SHW = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic [SWR-1:0] Data_i,
  input  logic [SHW-1:0] Shift_i,
  input  logic [EW-1:0]  Exp_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [SWR-1:0] Data_o,
  output logic [EW-1:0]  Exp_o,
  output logic           Zero_o,
  output logic           Underflow_o
);
  logic           s1_valid_q, s1_valid_d;
  logic [SWR-1:0] s1_data_q, s1_data_d;
  logic [2:0]     s1_fine_q, s1_fine_d;
  logic [EW-1:0]  s1_exp_q, s1_exp_d;
  logic           s1_zero_q, s1_zero_d;
  logic           s1_uf_q, s1_uf_d;
  logic           out_valid_q, out_valid_d;
  logic [SWR-1:0] data_q, data_d;
  logic [EW-1:0]  exp_q, exp_d;
  logic           zero_q, zero_d;
  logic           uf_q, uf_d;
  logic           s1_load, s2_load, in_fire, s2_fire, z, uf;
  logic [EW-1:0]  s_ext, eff;
  assign s2_load     = !out_valid_q | out_ready_i;
  assign s1_load     = !s1_valid_q | s2_load;
  assign in_ready_o  = s1_load;
  assign in_fire     = in_valid_i & s1_load;
  assign s2_fire     = s1_valid_q & s2_load;
  assign out_valid_o = out_valid_q;
  assign Data_o      = data_q;
  assign Exp_o       = exp_q;
  assign Zero_o      = zero_q;
  assign Underflow_o = uf_q;
  // stage 1: zero detect, clamp the shift to the exponent, coarse byte shift
  always_comb begin
    z          = Shift_i >= SHW'(SWR);
    s_ext      = EW'(Shift_i);
    uf         = !z && (s_ext > Exp_i);
    eff        = uf ? Exp_i : s_ext;
    s1_valid_d = s1_load ? in_valid_i : s1_valid_q;
    s1_data_d  = !in_fire ? s1_data_q : z ? '0 : Data_i << {eff[5:3], 3'b000};
    s1_fine_d  = !in_fire ? s1_fine_q : z ? 3'd0 : eff[2:0];
    s1_exp_d   = !in_fire ? s1_exp_q : z ? '0 : Exp_i - eff;
    s1_zero_d  = in_fire ? z : s1_zero_q;
    s1_uf_d    = in_fire ? uf : s1_uf_q;
  end
  // stage 2: fine bit shift; results hold while downstream stalls
  always_comb begin
    out_valid_d = s2_load ? s1_valid_q : out_valid_q;
    data_d      = s2_fire ? s1_data_q << s1_fine_q : data_q;
    exp_d       = s2_fire ? s1_exp_q : exp_q;
    zero_d      = s2_fire ? s1_zero_q : zero_q;
    uf_d        = s2_fire ? s1_uf_q : uf_q;
  end
  // pipeline registers; reset flushes every in-flight beat
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_fine_q   <= '0;
      s1_exp_q    <= '0;
      s1_zero_q   <= 1'b0;
      s1_uf_q     <= 1'b0;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      exp_q       <= '0;
      zero_q      <= 1'b0;
      uf_q        <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_fine_q   <= s1_fine_d;
      s1_exp_q    <= s1_exp_d;
      s1_zero_q   <= s1_zero_d;
      s1_uf_q     <= s1_uf_d;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      exp_q       <= exp_d;
      zero_q      <= zero_d;
      uf_q        <= uf_d;
    end
  end
endmodule

// File: tb/tb_fpu_norm_shift_pipe.sv
// tb_fpu_norm_shift_pipe: table vectors, stall/reset sequences and random stream vs reference model
module tb_fpu_norm_shift_pipe;
  typedef struct packed {
    logic [54:0] d;
    logic [10:0] e;
    logic        z;
    logic        u;
  } res_t;
  typedef struct {
    logic [54:0] d;
    logic [5:0]  s;
    logic [10:0] e;
    res_t        r;
  } vec_t;

  logic        clk = 0, rst = 1, in_valid_i = 0, out_ready_i = 1;
  logic        in_ready_o, out_valid_o, Zero_o, Underflow_o;
  logic [54:0] Data_i = '0, Data_o;
  logic [5:0]  Shift_i = '0;
  logic [10:0] Exp_i = '0, Exp_o;
  int          tests = 0, fails = 0;
  res_t        cur_exp;
  res_t        exp_q[$];
  vec_t        tbl[10];

  fpu_norm_shift_pipe dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .Data_i(Data_i), .Shift_i(Shift_i), .Exp_i(Exp_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .Data_o(Data_o), .Exp_o(Exp_o), .Zero_o(Zero_o), .Underflow_o(Underflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  function automatic res_t model(input logic [54:0] d, input logic [5:0] s, input logic [10:0] e);
    res_t r;
    int sh, ex, eff;
    sh = int'(s);
    ex = int'(e);
    r = '0;
    if (sh >= 55) begin
      r.z = 1'b1;
      return r;
    end
    eff = sh > ex ? ex : sh;
    r.d = d << eff;
    r.e = 11'(ex - eff);
    r.u = sh > ex;
    return r;
  endfunction

  function automatic res_t mk(input logic [54:0] d, input logic [10:0] e, input logic z, input logic u);
    res_t r;
    r.d = d; r.e = e; r.z = z; r.u = u;
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) exp_q.delete();
    else begin
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) chk("unexpected_beat", {Data_o, Exp_o, Zero_o, Underflow_o}, 128'hdead);
        else chk("beat", {Data_o, Exp_o, Zero_o, Underflow_o}, exp_q.pop_front());
      end
      if (in_valid_i && in_ready_o) exp_q.push_back(cur_exp);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [54:0] d, input logic [5:0] s, input logic [10:0] e, input res_t r);
    logic ok;
    ok = 0;
    Data_i = d; Shift_i = s; Exp_i = e; cur_exp = r; in_valid_i = 1;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready_o;
      cyc();
    end
    in_valid_i = 0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      if (exp_q.size() == 0 && !out_valid_o) return;
      cyc();
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    logic [127:0] snap;
    logic         rand_on;
    tbl[0] = '{55'd1 << 50, 6'd4, 11'd100, mk(55'd1 << 54, 11'd96, 0, 0)};
    tbl[1] = '{55'd1, 6'd54, 11'd200, mk(55'd1 << 54, 11'd146, 0, 0)};
    tbl[2] = '{55'd1 << 44, 6'd10, 11'd3, mk(55'd1 << 47, 11'd0, 0, 1)};
    tbl[3] = '{55'd0, 6'd55, 11'd500, mk(55'd0, 11'd0, 1, 0)};
    tbl[4] = '{55'd0, 6'd63, 11'd500, mk(55'd0, 11'd0, 1, 0)};
    tbl[5] = '{55'h123456789ABCD, 6'd0, 11'd77, mk(55'h123456789ABCD, 11'd77, 0, 0)};
    tbl[6] = '{{55{1'b1}}, 6'd60, 11'd2047, mk(55'd0, 11'd0, 1, 0)};
    tbl[7] = '{55'd1 << 40, 6'd5, 11'd5, mk(55'd1 << 45, 11'd0, 0, 0)};
    tbl[8] = '{{55{1'b1}}, 6'd8, 11'd1000, mk({{47{1'b1}}, 8'd0}, 11'd992, 0, 0)};
    tbl[9] = '{55'd1, 6'd20, 11'd0, mk(55'd1, 11'd0, 0, 1)};

    repeat (3) cyc();
    rst = 0;
    chk("reset_outputs", {out_valid_o, Data_o, Exp_o, Zero_o, Underflow_o}, 0);
    chk("reset_in_ready", in_ready_o, 1);

    send(tbl[0].d, tbl[0].s, tbl[0].e, tbl[0].r);
    chk("latency_c1", out_valid_o, 0);
    cyc();
    chk("latency_c2", out_valid_o, 1);
    drain();

    for (int i = 0; i < 10; i++) send(tbl[i].d, tbl[i].s, tbl[i].e, tbl[i].r);
    drain();

    out_ready_i = 0;
    fork
      for (int i = 1; i <= 4; i++) send(55'd1, 6'(i), 11'd100, mk(55'd1 << i, 11'(100 - i), 0, 0));
      begin
        cyc();
        cyc();
        chk("bp_in_ready_full", in_ready_o, 0);
        snap = {out_valid_o, Data_o, Exp_o, Zero_o, Underflow_o};
        chk("bp_first_out", snap, {1'b1, 55'd2, 11'd99, 2'b00});
        for (int k = 0; k < 3; k++) begin
          cyc();
          chk("bp_stable", {out_valid_o, Data_o, Exp_o, Zero_o, Underflow_o}, snap);
          chk("bp_in_ready_held", in_ready_o, 0);
        end
        out_ready_i = 1;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("bp_throughput", out_valid_o, 1);
        end
      end
    join
    drain();

    rand_on = 1;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [54:0] d;
          logic [5:0]  s;
          logic [10:0] e;
          d = 55'({$urandom(), $urandom()});
          s = 6'($urandom_range(0, 63));
          e = $urandom_range(0, 3) == 0 ? 11'($urandom_range(0, 60)) : 11'($urandom_range(0, 2047));
          send(d, s, e, model(d, s, e));
          if ($urandom_range(0, 4) == 0) cyc();
        end
        rand_on = 0;
      end
      while (rand_on) begin
        out_ready_i = $urandom_range(0, 3) != 0;
        cyc();
      end
    join
    out_ready_i = 1;
    drain();

    out_ready_i = 0;
    send(55'd5, 6'd1, 11'd50, mk(55'd10, 11'd49, 0, 0));
    send(55'd5, 6'd2, 11'd50, mk(55'd20, 11'd48, 0, 0));
    rst = 1;
    cyc();
    rst = 0;
    chk("midreset_outputs", {out_valid_o, Data_o, Exp_o, Zero_o, Underflow_o}, 0);
    chk("midreset_in_ready", in_ready_o, 1);
    out_ready_i = 1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("midreset_no_stale", out_valid_o, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
